// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states,
// and small legality/alignment helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  // Loads accept B/H/W/BU/HU; stores only B/H/W.
  function automatic logic is_legal(input logic wr, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !wr;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Halfwords need addr[0]=0, words need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    case (f3[1:0])
      2'b01:   mis = lo[0];
      2'b10:   mis = (lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Byte-lane steering: load extraction with sign/zero extension, and
// sub-word merge of store data into the old memory word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] mem_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] lo,
                                          input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_BU:   r = {24'h0, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'h0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] lo, input logic [2:0] f3);
    logic [31:0] r;
    r = old;
    case (f3)
      F3_B: r[{lo, 3'b000} +: 8] = wd[7:0];
      F3_H: begin
        if (lo[1]) r[31:16] = wd[15:0];
        else       r[15:0]  = wd[15:0];
      end
      default: r = wd;
    endcase
    return r;
  endfunction

  // Pure combinational steering; the caller decides which result to use.
  always_comb begin
    ld_data = extract(mem_word, addr_lo, funct3);
    st_word = merge(mem_word, wdata, addr_lo, funct3);
  end

endmodule

// File: rtl/load_store_unit.sv
// RISC-V load/store unit between execute and a word-wide, byte-addressed,
// little-endian data memory. Sub-word stores go through read-modify-write.
// All outputs are registered from the next-state decode so they are clean
// Moore signals and drop to zero immediately on reset.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_access_addr,
  output logic [31:0] mem_in,
  output logic        mem_write_en,
  output logic        mem_read_en,
  input  logic [31:0] mem_out
);

  lsu_state_e  state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;     // load result or word to be written
  logic        err_q, err_d;
  logic        req_ready_q, req_ready_d;
  logic        rd_en_q, rd_en_d;
  logic        wr_en_q, wr_en_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] mem_addr_q, mem_addr_d;

  logic [31:0] lane_word;
  logic [31:0] ld_data;
  logic [31:0] st_word;
  logic [31:0] eff_addr;
  logic        bad_req;

  // mem_out is only meaningful in READ; blocking it elsewhere keeps X out.
  assign lane_word = (state_q == ST_READ) ? mem_out : 32'h0;

  lsu_lane_align u_align (
    .mem_word (lane_word),
    .wdata    (wdata_q),
    .addr_lo  (addr_q[1:0]),
    .funct3   (f3_q),
    .ld_data  (ld_data),
    .st_word  (st_word)
  );

  // Incoming-request classification; with alignment checks off the low
  // address bits are forced to the access size instead of trapping.
  always_comb begin
    eff_addr = req_addr;
    if (!CHECK_ALIGN) begin
      case (req_funct3[1:0])
        2'b01:   eff_addr[0]   = 1'b0;
        2'b10:   eff_addr[1:0] = 2'b00;
        default: eff_addr      = req_addr;
      endcase
    end
    bad_req = !is_legal(req_write, req_funct3) ||
              (CHECK_ALIGN && is_misaligned(req_funct3, req_addr[1:0]));
  end

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          f3_d    = req_funct3;
          addr_d  = eff_addr;
          wdata_d = req_wdata;
          word_d  = req_wdata;     // SW writes the store data as-is
          err_d   = bad_req;
          if (bad_req)                            state_d = ST_RESP;
          else if (req_write && req_funct3 == F3_W) state_d = ST_WRITE;
          else                                    state_d = ST_READ;
        end
      end
      ST_READ: begin
        word_d  = write_q ? st_word : ld_data;
        state_d = write_q ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: state_d = ST_RESP;
      default:  state_d = ST_IDLE;
    endcase
    req_ready_d  = (state_d == ST_IDLE);
    rd_en_d      = (state_d == ST_READ);
    wr_en_d      = (state_d == ST_WRITE);
    resp_valid_d = (state_d == ST_RESP);
    mem_addr_d   = (rd_en_d || wr_en_d) ? {addr_d[31:2], 2'b00} : 32'h0;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      write_q      <= 1'b0;
      f3_q         <= 3'b000;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      word_q       <= 32'h0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      mem_addr_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      f3_q         <= f3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      word_q       <= word_d;
      err_q        <= err_d;
      req_ready_q  <= req_ready_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      resp_valid_q <= resp_valid_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  assign req_ready       = req_ready_q;
  assign mem_read_en     = rd_en_q;
  assign mem_write_en    = wr_en_q;
  assign mem_access_addr = mem_addr_q;
  assign mem_in          = wr_en_q ? word_q : 32'h0;
  assign resp_valid      = resp_valid_q;
  assign resp_err        = resp_valid_q & err_q;
  assign resp_rdata      = (resp_valid_q && !write_q && !err_q) ? word_q : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata, mem_access_addr, mem_in, mem_out;
  logic        mem_write_en, mem_read_en;

  int total = 0;
  int bad = 0;

  // memory model: 64 words, combinational read, posedge write
  logic [31:0] mem [0:63];
  logic        clr, pre_en;
  logic [5:0]  pre_idx;
  logic [31:0] pre_data;

  assign mem_out = mem[mem_access_addr[7:2]];

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    end else begin
      if (mem_write_en) mem[mem_access_addr[7:2]] <= mem_in;
      if (pre_en)       mem[pre_idx] <= pre_data;
    end
  end

  always #5 clk = ~clk;

  load_store_unit #(.CHECK_ALIGN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_access_addr(mem_access_addr), .mem_in(mem_in),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en), .mem_out(mem_out)
  );

  // results of the last issued request
  int          r_lat, r_nrd, r_nwr;
  logic [31:0] r_rdata, r_waddr, r_win;
  logic        r_err;

  task automatic preload(input logic [5:0] idx, input logic [31:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = idx; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Drive one request, then trace memory activity until resp_valid.
  // r_lat is the cycle (1 = first after accept) holding resp_valid; 0 = none.
  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d);
    int n;
    r_lat = 0; r_nrd = 0; r_nwr = 0; r_rdata = 'x; r_err = 1'bx;
    r_waddr = 'x; r_win = 'x;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin req_valid = 1'b0; return; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (mem_read_en) r_nrd++;
      if (mem_write_en) begin r_nwr++; r_waddr = mem_access_addr; r_win = mem_in; end
      if (resp_valid) begin r_lat = c; r_rdata = resp_rdata; r_err = resp_err; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    #2;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", req_ready); end
    total++; if ({resp_valid, resp_err, mem_write_en, mem_read_en} !== 4'b0) begin bad++;
      $display("FAIL rst_ctl got=%b exp=0000", {resp_valid, resp_err, mem_write_en, mem_read_en}); end
    total++; if ({resp_rdata, mem_in, mem_access_addr} !== 96'h0) begin bad++;
      $display("FAIL rst_data got=%h/%h/%h exp=0", resp_rdata, mem_in, mem_access_addr); end
  endtask

  task automatic test_loads;
    preload(6'h04, 32'h8899AABB);
    issue(1'b0, 3'b000, 32'h13, 32'h0);
    total++; if (r_lat !== 2) begin bad++; $display("FAIL lb_lat got=%0d exp=2", r_lat); end
    total++; if (r_rdata !== 32'hFFFFFF88 || r_err !== 1'b0) begin bad++;
      $display("FAIL lb_data got=%h err=%b exp=ffffff88 err=0", r_rdata, r_err); end
    issue(1'b0, 3'b100, 32'h12, 32'h0);
    total++; if (r_rdata !== 32'h00000099) begin bad++; $display("FAIL lbu_data got=%h exp=00000099", r_rdata); end
    issue(1'b0, 3'b001, 32'h12, 32'h0);
    total++; if (r_rdata !== 32'hFFFF8899) begin bad++; $display("FAIL lh_data got=%h exp=ffff8899", r_rdata); end
    issue(1'b0, 3'b101, 32'h10, 32'h0);
    total++; if (r_rdata !== 32'h0000AABB || r_nrd !== 1 || r_nwr !== 0) begin bad++;
      $display("FAIL lhu_data got=%h rd=%0d wr=%0d exp=0000aabb rd=1 wr=0", r_rdata, r_nrd, r_nwr); end
  endtask

  task automatic test_sub_stores;
    issue(1'b1, 3'b000, 32'h11, 32'h12345677);
    total++; if (r_lat !== 3) begin bad++; $display("FAIL sb_lat got=%0d exp=3", r_lat); end
    total++; if (r_nwr !== 1 || r_waddr !== 32'h10 || r_win !== 32'h889977BB) begin bad++;
      $display("FAIL sb_write got n=%0d a=%h d=%h exp n=1 a=10 d=889977bb", r_nwr, r_waddr, r_win); end
    total++; if (r_rdata !== 32'h0 || r_err !== 1'b0) begin bad++;
      $display("FAIL sb_resp got=%h err=%b exp=0 err=0", r_rdata, r_err); end
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    total++; if (r_rdata !== 32'h889977BB) begin bad++; $display("FAIL sb_lw got=%h exp=889977bb", r_rdata); end
    preload(6'h04, 32'h8899AABB);
    issue(1'b1, 3'b001, 32'h12, 32'h0000CAFE);
    total++; if (r_nrd !== 1 || r_win !== 32'hCAFEAABB) begin bad++;
      $display("FAIL sh_write got rd=%0d d=%h exp rd=1 d=cafeaabb", r_nrd, r_win); end
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    total++; if (r_rdata !== 32'hCAFEAABB) begin bad++; $display("FAIL sh_lw got=%h exp=cafeaabb", r_rdata); end
  endtask

  task automatic test_sw;
    issue(1'b1, 3'b010, 32'h14, 32'hDEADBEEF);
    total++; if (r_lat !== 2 || r_nrd !== 0 || r_nwr !== 1) begin bad++;
      $display("FAIL sw_seq got lat=%0d rd=%0d wr=%0d exp lat=2 rd=0 wr=1", r_lat, r_nrd, r_nwr); end
    total++; if (r_waddr !== 32'h14 || r_win !== 32'hDEADBEEF) begin bad++;
      $display("FAIL sw_write got a=%h d=%h exp a=14 d=deadbeef", r_waddr, r_win); end
    @(negedge clk);
    total++; if (mem[5] !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_mem got=%h exp=deadbeef", mem[5]); end
  endtask

  task automatic test_errors;
    issue(1'b0, 3'b010, 32'h12, 32'h0);
    total++; if (r_lat !== 1 || r_err !== 1'b1 || r_rdata !== 32'h0) begin bad++;
      $display("FAIL lw_misal got lat=%0d err=%b d=%h exp lat=1 err=1 d=0", r_lat, r_err, r_rdata); end
    total++; if (r_nrd !== 0 || r_nwr !== 0) begin bad++;
      $display("FAIL lw_misal_mem got rd=%0d wr=%0d exp 0 0", r_nrd, r_nwr); end
    issue(1'b0, 3'b011, 32'h10, 32'h0);
    total++; if (r_lat !== 1 || r_err !== 1'b1) begin bad++;
      $display("FAIL ld_f3_011 got lat=%0d err=%b exp lat=1 err=1", r_lat, r_err); end
    issue(1'b1, 3'b100, 32'h10, 32'h55555555);
    total++; if (r_err !== 1'b1 || r_nwr !== 0) begin bad++;
      $display("FAIL st_f3_100 got err=%b wr=%0d exp err=1 wr=0", r_err, r_nwr); end
    issue(1'b1, 3'b001, 32'h11, 32'h0000FFFF);
    total++; if (r_err !== 1'b1 || r_nrd !== 0 || r_nwr !== 0) begin bad++;
      $display("FAIL sh_misal got err=%b rd=%0d wr=%0d exp 1 0 0", r_err, r_nrd, r_nwr); end
    issue(1'b0, 3'b001, 32'h13, 32'h0);
    total++; if (r_err !== 1'b1 || r_rdata !== 32'h0) begin bad++;
      $display("FAIL lh_misal got err=%b d=%h exp err=1 d=0", r_err, r_rdata); end
  endtask

  task automatic test_reset_in_write;
    int n;
    logic saw_resp;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h18; req_wdata = 32'h11111111;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    total++; if (mem_write_en !== 1'b1) begin bad++; $display("FAIL rw_in_write got=%b exp=1", mem_write_en); end
    #2 rst = 1'b1;
    #1;
    total++; if (mem_write_en !== 1'b0 || mem_in !== 32'h0) begin bad++;
      $display("FAIL rw_drop got en=%b d=%h exp en=0 d=0", mem_write_en, mem_in); end
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rw_ready_low got=%b exp=0", req_ready); end
    saw_resp = 1'b0;
    @(posedge clk); #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rw_ready_high got=%b exp=1", req_ready); end
    for (int c = 0; c < 4; c++) begin
      if (resp_valid) saw_resp = 1'b1;
      @(posedge clk); #1;
    end
    total++; if (saw_resp !== 1'b0) begin bad++; $display("FAIL rw_no_resp got=%b exp=0", saw_resp); end
    total++; if (mem[6] !== 32'h0) begin bad++; $display("FAIL rw_mem got=%h exp=00000000", mem[6]); end
  endtask

  task automatic test_back_to_back;
    int n, lb_cyc;
    logic rdy3, rv3, rdy4;
    logic [31:0] lb_data;
    preload(6'h08, 32'h11223344);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h20; req_wdata = 32'h000000F0;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_write = 1'b0; req_funct3 = 3'b000; req_addr = 32'h20; req_wdata = 32'h0;
    rdy3 = 1'bx; rv3 = 1'bx; rdy4 = 1'bx; lb_cyc = 0; lb_data = 'x;
    for (int c = 1; c <= 12; c++) begin
      if (c == 3) begin rdy3 = req_ready; rv3 = resp_valid; end
      if (c == 4) rdy4 = req_ready;
      if (c == 5) req_valid = 1'b0;
      if (c > 4 && resp_valid && lb_cyc == 0) begin lb_cyc = c; lb_data = resp_rdata; end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    total++; if (rv3 !== 1'b1 || rdy3 !== 1'b0) begin bad++;
      $display("FAIL b2b_resp got rv=%b rdy=%b exp rv=1 rdy=0", rv3, rdy3); end
    total++; if (rdy4 !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", rdy4); end
    total++; if (lb_cyc !== 6 || lb_data !== 32'hFFFFFFF0) begin bad++;
      $display("FAIL b2b_lb got cyc=%0d d=%h exp cyc=6 d=fffffff0", lb_cyc, lb_data); end
    total++; if (mem[8] !== 32'h112233F0) begin bad++; $display("FAIL b2b_mem got=%h exp=112233f0", mem[8]); end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b1; pre_en = 1'b0; pre_idx = '0; pre_data = '0;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    test_reset;
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst = 1'b0; clr = 1'b0;
    test_loads;
    test_sub_stores;
    test_sw;
    test_errors;
    test_reset_in_write;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
